// File: rtl/proc_pkg.sv
// Shared opcodes, ALU encoding and FSM state type for the parametrised processor.
package proc_pkg;

    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_MVI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_LD   = 4'd8;
    localparam logic [3:0] OP_ST   = 4'd9;
    localparam logic [3:0] OP_MVNZ = 4'd10;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL
    } alu_op_e;

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        T3,
        MEMWAIT
    } state_e;

    // Map an instruction opcode (2..7) onto the ALU operation it performs.
    function automatic alu_op_e alu_op_of(input logic [3:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_SLT:  return ALU_SLT;
            OP_SLL:  return ALU_SLL;
            OP_SRL:  return ALU_SRL;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU: add, sub, and, signed slt, and range-checked logical shifts.
module proc_alu
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    localparam logic [DATA_W:0] SHIFT_LIM = (DATA_W + 1)'(DATA_W);

    // Any shift amount of DATA_W or more clears every bit.
    logic shift_all;
    assign shift_all = {1'b0, b} >= SHIFT_LIM;

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_SLT: result = DATA_W'($signed(a) < $signed(b));
            ALU_SLL: result = shift_all ? '0 : (a << b);
            ALU_SRL: result = shift_all ? '0 : (a >> b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/proc_param.sv
// Parametrised multi-cycle processor with a req/ack data-memory port for ld/st.
// Optional macro PROC_MVNZ_EN turns opcode 10 into mvnz (Rx <= Ry when G != 0).
module proc_param
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic              Done,
    output logic [DATA_W-1:0] BusWires,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned RSEL_W = $clog2(NREGS);
    localparam int unsigned IR_W   = 4 + 2 * RSEL_W;

    state_e              state, state_nxt;
    logic [IR_W-1:0]     ir;
    logic [DATA_W-1:0]   regs [NREGS];
    logic [DATA_W-1:0]   a_reg, g_reg, alu_res;

    logic [3:0]          op;
    logic [RSEL_W-1:0]   rx, ry;
    logic                ir_we, r_we, a_we, g_we, mem_cap;

    assign op = ir[3:0];
    assign rx = ir[4 +: RSEL_W];
    assign ry = ir[4 + RSEL_W +: RSEL_W];

    assign mem_req = (state == MEMWAIT);

    proc_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (alu_op_of(op)),
        .a      (a_reg),
        .b      (BusWires),
        .result (alu_res)
    );

    // Next state, bus source, write enables and Done decode.
    always_comb begin
        state_nxt = state;
        BusWires  = '0;
        Done      = 1'b0;
        ir_we     = 1'b0;
        r_we      = 1'b0;
        a_we      = 1'b0;
        g_we      = 1'b0;
        mem_cap   = 1'b0;
        case (state)
            IDLE: begin
                if (Run) begin
                    ir_we     = 1'b1;
                    state_nxt = T1;
                end
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        BusWires  = regs[ry];
                        r_we      = 1'b1;
                        Done      = 1'b1;
                        state_nxt = IDLE;
                    end
                    OP_MVI: begin
                        BusWires  = DIN;
                        r_we      = 1'b1;
                        Done      = 1'b1;
                        state_nxt = IDLE;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_SLT, OP_SLL, OP_SRL: begin
                        BusWires  = regs[rx];
                        a_we      = 1'b1;
                        state_nxt = T2;
                    end
                    OP_LD, OP_ST: begin
                        mem_cap   = 1'b1;
                        state_nxt = MEMWAIT;
                    end
`ifdef PROC_MVNZ_EN
                    OP_MVNZ: begin
                        if (g_reg != '0) begin
                            BusWires = regs[ry];
                            r_we     = 1'b1;
                        end
                        Done      = 1'b1;
                        state_nxt = IDLE;
                    end
`endif
                    default: begin
                        Done      = 1'b1;
                        state_nxt = IDLE;
                    end
                endcase
            end
            T2: begin
                BusWires  = regs[ry];
                g_we      = 1'b1;
                state_nxt = T3;
            end
            T3: begin
                BusWires  = g_reg;
                r_we      = 1'b1;
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            MEMWAIT: begin
                if (mem_ack) begin
                    Done      = 1'b1;
                    state_nxt = IDLE;
                    if (op == OP_LD) begin
                        BusWires = mem_rdata;
                        r_we     = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, register file, A/G and memory-port holding registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            ir        <= '0;
            a_reg     <= '0;
            g_reg     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (ir_we) ir <= DIN[IR_W-1:0];
            if (a_we)  a_reg <= BusWires;
            if (g_we)  g_reg <= alu_res;
            if (r_we)  regs[rx] <= BusWires;
            // Address, data and direction are frozen for the whole MEMWAIT span.
            if (mem_cap) begin
                mem_addr  <= ADDR_W'(regs[ry]);
                mem_wdata <= regs[rx];
                mem_we    <= (op == OP_ST);
            end
        end
    end

endmodule

// File: doc/proc_param.md
Name: proc_param

Overview:
- Parametrised successor to the team's multi-cycle 16-bit processor.
- Generalised in data width and register count, with an explicit state machine.
- Adds a request/acknowledge data-memory port for ld/st with wait states, plus a defined NOP for unknown opcodes.
- Sits between the instruction/immediate source (DIN + Run) and the data memory; BusWires is exported for debug/display.

Parameters:
- DATA_W, 16: register, bus and ALU width.
- NREGS, 8: number of general registers; must be a power of two, at least 2.
- ADDR_W, 16: mem_addr width; taken from the low ADDR_W bits of Ry, zero-extended if ADDR_W > DATA_W.
- Derived, not overridable: RSEL_W = log2(NREGS); IR_W = 4 + 2*RSEL_W. The instruction layout is {Y[RSEL_W], X[RSEL_W], I[4]}, with I in the LSBs.

Ports:
- Clock, input, 1: single clock; all state updates on its rising edge.
- Reset, input, 1: synchronous, active-high.
- Run, input, 1: instruction valid; sampled only in state IDLE.
- DIN, input, DATA_W: instruction in the low IR_W bits; carries the immediate in the cycle after an mvi fetch.
- Done, output, 1: one-cycle pulse, high in the final cycle of each instruction.
- BusWires, output, DATA_W: value on the internal bus this cycle.
- mem_req, output, 1: memory request; held until acknowledged.
- mem_we, output, 1: 1 = store, 0 = load; valid while mem_req is high.
- mem_addr, output, ADDR_W: memory address, valid while mem_req is high.
- mem_wdata, output, DATA_W: store data, valid while mem_req is high.
- mem_rdata, input, DATA_W: load data, valid in the mem_ack cycle.
- mem_ack, input, 1: completes the outstanding request.

Behaviour:
- Reset (synchronous, Reset=1 at a rising edge) puts the block in this state:
  - state = IDLE;
  - R0..R(NREGS-1), A, G and IR all = 0;
  - Done = 0, mem_req = 0, mem_we = 0, BusWires = 0.
- Reset mid-instruction, including during MEMWAIT, aborts with no register write; mem_req drops the next cycle.
- States: IDLE, T1, T2, T3, MEMWAIT.
- IDLE:
  - Run=1 loads IR <= DIN[IR_W-1:0] and moves to T1.
  - Run=0 stays in IDLE.
  - Run is ignored in every other state.
- Opcodes (I):
  - 0 mv: T1 drives bus=Ry and writes Rx; Done; go to IDLE.
  - 1 mvi: T1 drives bus=DIN and writes Rx; Done; go to IDLE.
  - 2..7 add, sub, and, slt, sll, srl:
    - T1: bus=Rx, A <= bus.
    - T2: bus=Ry, G <= A op bus.
    - T3: bus=G, Rx <= G; Done; go to IDLE.
  - 8 ld: T1 enters MEMWAIT with mem_addr = Ry and mem_we = 0.
  - 9 st: T1 enters MEMWAIT with mem_addr = Ry, mem_wdata = Rx and mem_we = 1.
  - 10–15: NOP; Done in T1, no write, return to IDLE.
- MEMWAIT:
  - mem_req = 1, with address, data and we held stable until mem_ack.
  - ld ack cycle: bus = mem_rdata, Rx <= mem_rdata, Done; return to IDLE.
  - st ack cycle: Done, no register write; return to IDLE.
  - mem_ack outside MEMWAIT is ignored.
  - There is no timeout.
- Latency from the Run cycle to the Done cycle:
  - mv, mvi, NOP: 1 cycle.
  - ALU ops: 3 cycles.
  - ld, st: 1 + (MEMWAIT cycles up to and including the ack cycle).
- Done is a combinational decode of state and I.
  - With Run held high, a new instruction is accepted the cycle after Done.
- Arithmetic:
  - add/sub wrap modulo 2^DATA_W.
  - and is bitwise.
  - slt: signed compare of Rx and Ry, result zero-extended 1 or 0.
  - sll/srl are logical shifts of Rx by the full unsigned Ry; the result is 0 when Ry >= DATA_W.
- When X == Y, the source is read before the write (e.g. add R2,R2 doubles R2).
- BusWires is 0 in IDLE and in MEMWAIT cycles without an ack.

Optional Feature:
- Macro: PROC_MVNZ_EN.
- Defined: opcode 10 is mvnz — in T1, if G != 0 then Rx <= Ry with bus = Ry; Done in T1 either way.
- Not defined: opcode 10 is a NOP like 11–15.

Decomposition:
- Package proc_pkg holds:
  - the opcode constants OP_MV … OP_ST, OP_MVNZ;
  - the ALU op encoding (ADD, SUB, AND, SLT, SLL, SRL);
  - the state enum (IDLE, T1, T2, T3, MEMWAIT).
- One sub-module, proc_alu:
  - parameter DATA_W;
  - inputs op, a, b; output result;
  - purely combinational.
- Register file, bus mux and FSM stay in proc_param.

Test Plan (DATA_W=16, NREGS=8 unless noted):
- mvi R3,0x1234, then mv R5,R3 -> R5 = 0x1234; Done pulses once per instruction, 1 cycle after each Run cycle.
- R1 = 0xFFFF, R2 = 1, add R1,R2 -> R1 = 0x0000 at the T3 edge; Done in cycle 3. Then slt with R1 = 0x8000, R2 = 1 -> R1 = 1.
- R4 = 0x0001, R6 = 16, sll R4,R6 -> R4 = 0. With R6 = 15 -> R4 = 0x8000.
- st R7 -> [R0 = 0x20], ack delayed 3 cycles:
  - mem_req high 4 cycles with addr 0x20, we = 1 and wdata = R7 stable;
  - Done in the ack cycle.
  - Then ld R2 with rdata = 0xBEEF -> R2 = 0xBEEF.
- Reset asserted during MEMWAIT of ld -> the next cycle shows mem_req = 0, state IDLE, no Done, all registers 0; a later mem_ack is ignored.
- Opcode 0xF -> Done in T1, no register changes. With PROC_MVNZ_EN and G = 0, opcode 10 does not write; with G != 0 it writes Rx <= Ry. NREGS=16, DATA_W=32 build passes the add scenario.
